// File: rtl/fifo_rr_arb.sv
// fifo_rr_arb: burst-locked round-robin merge of N valid/ready streams into one registered, source-tagged output.
// Optional: define FIFO_RR_ARB_MAX_BURST_EN to force re-arbitration after MAX_BURST beats of a grant.
module fifo_rr_arb #(
  parameter int  N         = 4,
  parameter type DATA_t    = logic [63:0],
  parameter int  SRC_W     = (N > 1) ? $clog2(N) : 1,
  parameter int  MAX_BURST = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  DATA_t [N-1:0]      req_data_i,
  input  logic  [N-1:0]      req_last_i,
  input  logic  [N-1:0]      req_valid_i,
  output logic  [N-1:0]      req_ready_o,
  output DATA_t              out_data_o,
  output logic  [SRC_W-1:0]  out_src_o,
  output logic               out_last_o,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic               busy_o
);

  if (N < 1 || MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_rr_arb: N and MAX_BURST must both be >= 1");
  end

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e           state_q, state_d;
  logic [SRC_W-1:0] prio_q, prio_d, lock_q, lock_d, sel, ci;
  logic             slot_free, have, acc, rel_grant, cap_hit;

  function automatic logic [SRC_W-1:0] nxt(input logic [SRC_W-1:0] i);
    return (i == SRC_W'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign slot_free = !out_valid_o || out_ready_i;
  assign busy_o    = (state_q == LOCKED);

  // Candidate selection: the lock owner, or the first valid requester from prio onward.
  always_comb begin
    sel  = prio_q;
    have = 1'b0;
    ci   = prio_q;
    for (int k = 0; k < N; k++) begin
      if (!have && req_valid_i[ci]) begin
        have = 1'b1;
        sel  = ci;
      end
      ci = nxt(ci);
    end
    if (state_q == LOCKED) begin
      sel  = lock_q;
      have = 1'b1;
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (have) req_ready_o[sel] = slot_free;
  end

  assign acc       = have && slot_free && req_valid_i[sel];
  assign rel_grant = acc && (req_last_i[sel] || cap_hit);

`ifdef FIFO_RR_ARB_MAX_BURST_EN
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  logic [CNT_W-1:0] cnt_q;

  assign cap_hit = (cnt_q == CNT_W'(MAX_BURST - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i)    cnt_q <= '0;
    else if (acc) cnt_q <= rel_grant ? '0 : cnt_q + 1'b1;
  end
`else
  assign cap_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    lock_d  = lock_q;
    if (acc) begin
      // Priority only moves when a new grant is taken, not on every locked beat.
      if (state_q == IDLE) begin
        prio_d = nxt(sel);
        lock_d = sel;
      end
      state_d = rel_grant ? IDLE : LOCKED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      prio_q  <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      lock_q  <= lock_d;
    end
  end

  // Output slot reloads whenever it is free; fields are zeroed when no beat moves in.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      out_last_o  <= 1'b0;
    end else if (slot_free) begin
      out_valid_o <= acc;
      out_data_o  <= acc ? req_data_i[sel] : '0;
      out_src_o   <= acc ? sel : '0;
      out_last_o  <= acc && req_last_i[sel];
    end
  end

endmodule

// File: tb/tb_fifo_rr_arb.sv
// tb_fifo_rr_arb: randomized + directed bench against a queue-based round-robin reference model.
module tb_fifo_rr_arb;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int MB = 2;
`ifdef FIFO_RR_ARB_MAX_BURST_EN
  localparam bit MAXEN = 1'b1;
`else
  localparam bit MAXEN = 1'b0;
`endif

  typedef logic [63:0] data_t;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  data_t [N-1:0]        req_data_i;
  logic  [N-1:0]        req_last_i, req_valid_i, req_ready_o;
  data_t                out_data_o;
  logic  [SW-1:0]       out_src_o;
  logic                 out_last_o, out_valid_o, out_ready_i, busy_o;

  fifo_rr_arb #(.N(N), .DATA_t(data_t), .MAX_BURST(MB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .out_data_o(out_data_o), .out_src_o(out_src_o), .out_last_o(out_last_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Per-requester pending beats, and a log of beats leaving the output.
  logic [63:0] qd [N][$];
  logic        ql [N][$];
  int          lsrc [$];
  logic [63:0] ldat [$];
  int          vprob [N];
  bit          hold_low [N];
  int          rprob;
  int          serial = 0;

  // Reference model state.
  bit          m_busy;
  int          m_owner, m_prio, m_cnt;
  logic        e_valid, e_last;
  logic [63:0] e_data;
  int          e_src;

  task automatic burst(input int r, input int len, input logic [63:0] base);
    for (int k = 0; k < len; k++) begin
      qd[r].push_back(base + 64'(k));
      ql[r].push_back(k == len - 1);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (qd[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input int acc_who);
    for (int i = 0; i < N; i++) begin
      if (i == acc_who) req_valid_i[i] = 1'b0;
      if (!req_valid_i[i] && !rst_i && qd[i].size() > 0 && !hold_low[i] &&
          int'($urandom_range(99)) < vprob[i]) begin
        req_valid_i[i] = 1'b1;
        req_data_i[i]  = qd[i][0];
        req_last_i[i]  = ql[i][0];
      end
    end
    out_ready_i = int'($urandom_range(99)) < rprob;
  endtask

  task automatic cycle();
    int       who;
    logic     sf, acc, lst, done;
    logic [N-1:0] er;
    @(negedge clk_i);
    sf  = !e_valid || out_ready_i;
    who = -1;
    if (m_busy) who = m_owner;
    else
      for (int k = 0; k < N; k++)
        if (who < 0 && req_valid_i[2'((m_prio + k) % N)]) who = (m_prio + k) % N;
    er = '0;
    if (who >= 0 && sf) er = N'(1) << who;
    if (!rst_i) chk("ready", req_ready_o, er);
    if (out_valid_o && out_ready_i) begin
      lsrc.push_back(int'(out_src_o));
      ldat.push_back(out_data_o);
    end
    @(posedge clk_i);
    acc = !rst_i && who >= 0 && sf && req_valid_i[2'(who)];
    if (rst_i) begin
      m_busy = 0; m_prio = 0; m_cnt = 0; m_owner = 0;
      e_valid = 0; e_data = '0; e_src = 0; e_last = 0;
    end else begin
      if (sf) begin
        e_valid = acc;
        e_data  = acc ? req_data_i[2'(who)] : 64'd0;
        e_src   = acc ? who : 0;
        e_last  = acc ? req_last_i[2'(who)] : 1'b0;
      end
      if (acc) begin
        lst = req_last_i[2'(who)];
        if (!m_busy) m_prio = (who + 1) % N;
        done    = lst || (MAXEN && m_cnt == MB - 1);
        m_cnt   = done ? 0 : m_cnt + 1;
        m_busy  = !done;
        m_owner = who;
        void'(qd[who].pop_front());
        void'(ql[who].pop_front());
      end
    end
    #1;
    chk("out_valid", out_valid_o, e_valid);
    chk("out_data",  out_data_o,  e_data);
    chk("out_src",   out_src_o,   e_src);
    chk("out_last",  out_last_o,  e_last);
    chk("busy",      busy_o,      m_busy);
    drive(acc ? who : -1);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    cycle();
    rst_i = 1'b0;
    drive(-1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pending() || out_valid_o || req_valid_i != '0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask

  initial begin
    int t2s [6];
    logic [63:0] t2d [6];
    int t6s [6];
    logic [63:0] held;
    int n;

    rst_i = 1'b1; req_valid_i = '0; req_data_i = '0; req_last_i = '0; out_ready_i = 1'b0;
    rprob = 100;
    for (int i = 0; i < N; i++) begin vprob[i] = 100; hold_low[i] = 0; end
    m_busy = 0; m_owner = 0; m_prio = 0; m_cnt = 0;
    e_valid = 0; e_data = '0; e_src = 0; e_last = 0;

    do_reset();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);

    // Single-beat bursts from all requesters: strict rotation.
    for (int rep = 0; rep < 3; rep++)
      for (int r = 0; r < N; r++) burst(r, 1, 64'(r * 256 + rep));
    drive(-1);
    lsrc.delete(); ldat.delete();
    drain(100);
    chk("t1_count", lsrc.size(), 12);
    for (int k = 0; k < lsrc.size() && k < 12; k++) chk("t1_src", lsrc[k], k % N);

    // Locked 4-beat burst from requester 2 with 0 and 1 contending.
    lsrc.delete(); ldat.delete();
    burst(2, 4, 64'hA0);
    drive(-1);
    cycle();
    burst(0, 1, 64'h100);
    burst(1, 1, 64'h200);
    drain(100);
    if (MAXEN) begin
      t2s = '{2, 2, 0, 1, 2, 2};
      t2d = '{64'hA0, 64'hA1, 64'h100, 64'h200, 64'hA2, 64'hA3};
    end else begin
      t2s = '{2, 2, 2, 2, 0, 1};
      t2d = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'h100, 64'h200};
    end
    chk("t2_count", lsrc.size(), 6);
    for (int k = 0; k < lsrc.size() && k < 6; k++) begin
      chk("t2_src", lsrc[k], t2s[k]);
      chk("t2_data", ldat[k], t2d[k]);
    end

    // Downstream stall: output beat must hold, no ready granted.
    burst(0, 3, 64'h300);
    rprob = 0;
    drive(-1);
    cycle();
    held = out_data_o;
    repeat (5) cycle();
    chk("t3_hold", out_data_o, held);
    chk("t3_ready", req_ready_o, 0);
    chk("t3_valid", out_valid_o, 1);
    rprob = 100;
    drain(100);

    // Reset while locked on requester 1.
    burst(1, 6, 64'h400);
    drive(-1);
    n = 0;
    while (!(m_busy && m_owner == 1) && n < 10) begin cycle(); n++; end
    chk("t4_lock", busy_o, 1);
    cycle();
    burst(0, 1, 64'h500);
    do_reset();
    chk("t4_busy", busy_o, 0);
    chk("t4_oval", out_valid_o, 0);
    cycle();
    chk("t4_src", out_src_o, 0);
    chk("t4_data", out_data_o, 64'h500);
    drain(100);

    // Owner's valid drops mid-burst while requester 0 waits.
    lsrc.delete(); ldat.delete();
    burst(3, 5, 64'h600);
    drive(-1);
    n = 0;
    while (qd[3].size() > 4 && n < 10) begin cycle(); n++; end
    hold_low[3] = 1;
    cycle();
    burst(0, 1, 64'h700);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t5_busy", busy_o, MAXEN ? 0 : 1);
    end
    hold_low[3] = 0;
    drain(100);
    chk("t5_order", lsrc[lsrc.size() - 1], MAXEN ? 3 : 0);

    // Long burst from 0 against single beat from 1, from a fresh reset.
    do_reset();
    lsrc.delete(); ldat.delete();
    burst(0, 5, 64'h800);
    burst(1, 1, 64'h900);
    drive(-1);
    drain(100);
    if (MAXEN) t6s = '{0, 0, 1, 0, 0, 0};
    else       t6s = '{0, 0, 0, 0, 0, 1};
    chk("t6_count", lsrc.size(), 6);
    for (int k = 0; k < lsrc.size() && k < 6; k++) chk("t6_src", lsrc[k], t6s[k]);

    // Random traffic and backpressure.
    rprob = 70;
    for (int i = 0; i < N; i++) vprob[i] = 60;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N; r++)
        if (qd[r].size() == 0 && $urandom_range(7) == 0) begin
          serial++;
          burst(r, 1 + int'($urandom_range(4)), {16'(r), 48'(serial) << 8});
        end
      cycle();
    end
    rprob = 100;
    for (int i = 0; i < N; i++) vprob[i] = 100;
    drain(500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
